iot_riscv_trap_ctrl: RTL and testbench
======================================

Name: iot_riscv_trap_ctrl

Overview:
- Trap initiator for the CSR file: detects synchronous exceptions, external/timer interrupts and MRET at the EX stage.
- Sequences the CSR writes for mepc and mcause over the single CSR write port, flushes the pipeline and redirects the PC to the trap vector or to mepc.
- Owns mstatus.MIE/MPIE and reads mtvec/mepc back from the CSR file.

Parameters:
- pc_size_p, 32, width of PC ports; PCs are zero-extended to 32 bit for CSR data and truncated for redirect.

Ports:
- main_clk_i  input  1  clock
- main_rst_an_i  input  1  async reset, low-active
- ex_instr_valid_i  input  1  valid instruction in EX (interrupt boundary)
- ex_pc_i  input  pc_size_p  PC of EX instruction
- ex_exc_valid_i  input  1  synchronous exception in EX
- ex_exc_cause_i  input  4  exception code
- ex_mret_i  input  1  MRET in EX
- irq_ext_i  input  1  external interrupt, level
- irq_timer_i  input  1  timer interrupt, level
- pipe_idle_i  input  1  pipeline drained (no outstanding bus access)
- mtvec_i  input  32  from CSR file
- mepc_i  input  32  from CSR file
- sw_mstatus_we_i  input  1  software write of mstatus
- sw_mstatus_wdata_i  input  32  write data; bit3=MIE, bit7=MPIE
- csr_wr_en_o  output  1  CSR write strobe
- csr_wr_addr_o  output  12  CSR address
- csr_wr_data_o  output  32  CSR data
- flush_o  output  1  kill IF/ID/EX
- stall_o  output  1  hold fetch
- pc_redirect_valid_o  output  1  one-cycle redirect strobe
- pc_redirect_o  output  pc_size_p  redirect target
- mstatus_o  output  32  {24'b0,MPIE,3'b0,MIE,3'b0}

Behaviour:
- Reset: state IDLE, MIE=0, MPIE=0, latched epc/cause=0, all outputs 0.
- FSM states: IDLE, DRAIN, SAVE_EPC, SAVE_CAUSE, REDIRECT, MRET.
- Events are sampled only in IDLE; in any other state all event inputs are ignored.
- Priority in IDLE, highest first:
  1. ex_exc_valid_i: cause = {1'b0, 27'b0, ex_exc_cause_i}.
  2. irq_ext_i & MIE & ex_instr_valid_i: cause = 0x8000000B.
  3. irq_timer_i & MIE & ex_instr_valid_i: cause = 0x80000007.
  4. ex_mret_i.
- On any trap event: latch epc = ex_pc_i, latch cause, next state DRAIN. The EX instruction does not retire.
- Exception plus MRET in the same cycle: exception wins.
- MRET with a pending enabled interrupt: the interrupt wins, and epc is the MRET PC.
- DRAIN: flush_o=1, stall_o=1. Stays until pipe_idle_i=1, then goes to SAVE_EPC. Unbounded wait is allowed.
- SAVE_EPC: stall_o=1, csr_wr_en_o=1, addr 0x341, data = zero-extended epc.
- SAVE_CAUSE: stall_o=1, csr_wr_en_o=1, addr 0x342, data = cause.
- REDIRECT: pc_redirect_valid_o=1 for one cycle; MPIE<=MIE, MIE<=0; return to IDLE. Target:
  - mtvec_i[1:0]==01 and cause is an interrupt: (mtvec_i & ~3) + 4*cause[3:0].
  - otherwise: mtvec_i & ~3.
- MRET (entered from IDLE on ex_mret_i; no drain): flush_o=1, pc_redirect_valid_o=1, pc_redirect_o = mepc_i[pc_size_p-1:0]; MIE<=MPIE, MPIE<=1; next state IDLE. MRET takes exactly 1 cycle.
- Latency, exception to redirect strobe: 4 cycles with pipe_idle_i already high (event cycle, DRAIN, SAVE_EPC, SAVE_CAUSE, strobe on the 4th).
- csr_wr_en_o is never asserted outside SAVE_EPC and SAVE_CAUSE.
- Software mstatus write:
  - Accepted only in IDLE with no event that cycle.
  - Otherwise dropped: FSM update wins.
  - Mid-trap writes are lost, not deferred.
- Vector add is 32-bit and wraps modulo 2^32. epc/cause latches are updated only in IDLE.
- Reset mid-sequence: immediate return to IDLE. A partial CSR write sequence is abandoned; no redirect is issued.
- Interrupts are level-sensitive and not latched: a deasserted irq before the sample is never taken.

Decomposition:
- iot_riscv_pkg holds:
  - CSR address constants (MTVEC 0x305, MSCRATCH 0x340, MEPC 0x341, MCAUSE 0x342, MSTATUS 0x300).
  - Cause code constants (IRQ_EXT 11, IRQ_TIMER 7).
  - The trap FSM state enum typedef.
- One sub-module, iot_riscv_trap_arb: combinational priority arbiter producing take_trap, take_mret and cause[31:0].

Test Plan:
- Exception: ex_exc_valid_i=1, cause=2, ex_pc_i=0x100, pipe_idle_i=1, mtvec=0x200 -> writes (0x341,0x100) then (0x342,0x2); redirect 0x200 on 4th cycle; MIE 1->0, MPIE=1.
- Vectored timer IRQ: MIE=1, irq_timer_i=1, ex_instr_valid_i=1, ex_pc_i=0x40, mtvec=0x301 -> mcause 0x80000007, redirect 0x31C. Same stimulus with MIE=0 -> no activity.
- Simultaneous: exception cause 3 with irq_ext_i=1, MIE=1 -> mcause 0x3; ext IRQ then taken after redirect once ex_instr_valid_i returns with MIE re-enabled by MRET.
- MRET: MPIE=1, MIE=0, mepc_i=0x104 -> single-cycle flush + redirect 0x104, MIE=1, MPIE=1, no CSR write.
- Drain hold: pipe_idle_i=0 for 5 cycles after exception -> flush_o/stall_o held 5 cycles, no csr_wr_en_o until pipe_idle_i rises. Software mstatus write during drain is ignored.
- Reset asserted in SAVE_CAUSE -> outputs 0 asynchronously, MIE=0, no redirect. After release, IDLE accepts new exception normally.

Source files
------------

// File: rtl/iot_riscv_pkg.sv
// Shared constants and types for the machine-mode trap logic.
package iot_riscv_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;

    // Interrupt cause codes (mcause[3:0] with mcause[31]=1)
    localparam logic [3:0] CAUSE_IRQ_EXT   = 4'd11;
    localparam logic [3:0] CAUSE_IRQ_TIMER = 4'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_SAVE_EPC,
        ST_SAVE_CAUSE,
        ST_REDIRECT,
        ST_MRET
    } trap_state_t;

endpackage

// File: rtl/iot_riscv_trap_arb.sv
// Priority arbiter for EX-stage trap events: exception > ext irq > timer irq > mret.
module iot_riscv_trap_arb
    import iot_riscv_pkg::*;
(
    input  logic        exc_valid,
    input  logic [3:0]  exc_cause,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        mie,
    input  logic        instr_valid,
    input  logic        mret,
    output logic        take_trap,
    output logic        take_mret,
    output logic [31:0] cause
);

    logic ext_en;
    logic timer_en;

    // Interrupts are only taken on a valid instruction boundary with MIE set
    assign ext_en   = irq_ext & mie & instr_valid;
    assign timer_en = irq_timer & mie & instr_valid;

    // Pick the highest-priority event and build its mcause value
    always_comb begin
        take_trap = 1'b0;
        take_mret = 1'b0;
        cause     = 32'h0;
        if (exc_valid) begin
            take_trap = 1'b1;
            cause     = {28'h0, exc_cause};
        end else if (ext_en) begin
            take_trap = 1'b1;
            cause     = {1'b1, 27'h0, CAUSE_IRQ_EXT};
        end else if (timer_en) begin
            take_trap = 1'b1;
            cause     = {1'b1, 27'h0, CAUSE_IRQ_TIMER};
        end else if (mret) begin
            take_mret = 1'b1;
        end
    end

endmodule

// File: rtl/iot_riscv_trap_ctrl.sv
// Trap sequencer: saves mepc/mcause through the CSR write port, flushes and
// redirects the pipeline, and owns mstatus.MIE/MPIE.
module iot_riscv_trap_ctrl
    import iot_riscv_pkg::*;
#(
    parameter int pc_size_p = 32
) (
    input  logic                 main_clk_i,
    input  logic                 main_rst_an_i,
    input  logic                 ex_instr_valid_i,
    input  logic [pc_size_p-1:0] ex_pc_i,
    input  logic                 ex_exc_valid_i,
    input  logic [3:0]           ex_exc_cause_i,
    input  logic                 ex_mret_i,
    input  logic                 irq_ext_i,
    input  logic                 irq_timer_i,
    input  logic                 pipe_idle_i,
    input  logic [31:0]          mtvec_i,
    input  logic [31:0]          mepc_i,
    input  logic                 sw_mstatus_we_i,
    input  logic [31:0]          sw_mstatus_wdata_i,
    output logic                 csr_wr_en_o,
    output logic [11:0]          csr_wr_addr_o,
    output logic [31:0]          csr_wr_data_o,
    output logic                 flush_o,
    output logic                 stall_o,
    output logic                 pc_redirect_valid_o,
    output logic [pc_size_p-1:0] pc_redirect_o,
    output logic [31:0]          mstatus_o
);

    trap_state_t state_q, state_d;
    logic [31:0] epc_q, cause_q;
    logic        mie_q, mpie_q;
    logic        take_trap, take_mret;
    logic [31:0] arb_cause;
    logic        in_idle;
    logic [31:0] vec_base, trap_tgt;
    logic        unused_wdata;

    // Only MIE/MPIE of the software write are implemented
    assign unused_wdata = ^{sw_mstatus_wdata_i[31:8], sw_mstatus_wdata_i[6:4],
                            sw_mstatus_wdata_i[2:0]};

    assign in_idle = (state_q == ST_IDLE);

    iot_riscv_trap_arb u_arb (
        .exc_valid   (ex_exc_valid_i),
        .exc_cause   (ex_exc_cause_i),
        .irq_ext     (irq_ext_i),
        .irq_timer   (irq_timer_i),
        .mie         (mie_q),
        .instr_valid (ex_instr_valid_i),
        .mret        (ex_mret_i),
        .take_trap   (take_trap),
        .take_mret   (take_mret),
        .cause       (arb_cause)
    );

    // Trap target: vectored mode offsets interrupts by 4*cause, wrapping mod 2^32
    assign vec_base = {mtvec_i[31:2], 2'b00};
    assign trap_tgt = (mtvec_i[1:0] == 2'b01 && cause_q[31])
                    ? vec_base + {26'h0, cause_q[3:0], 2'b00}
                    : vec_base;

    // Next-state logic; events are only looked at in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (take_trap)      state_d = ST_DRAIN;
                else if (take_mret) state_d = ST_MRET;
            end
            ST_DRAIN:      if (pipe_idle_i) state_d = ST_SAVE_EPC;
            ST_SAVE_EPC:   state_d = ST_SAVE_CAUSE;
            ST_SAVE_CAUSE: state_d = ST_REDIRECT;
            ST_REDIRECT:   state_d = ST_IDLE;
            ST_MRET:       state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // State register plus epc/cause latches, captured on trap entry only
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            state_q <= ST_IDLE;
            epc_q   <= 32'h0;
            cause_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (in_idle && take_trap) begin
                epc_q   <= 32'(ex_pc_i);
                cause_q <= arb_cause;
            end
        end
    end

    // mstatus MIE/MPIE: trap/mret updates win, software writes only when quiet
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            mie_q  <= 1'b0;
            mpie_q <= 1'b0;
        end else begin
            case (state_q)
                ST_REDIRECT: begin
                    mpie_q <= mie_q;
                    mie_q  <= 1'b0;
                end
                ST_MRET: begin
                    mie_q  <= mpie_q;
                    mpie_q <= 1'b1;
                end
                ST_IDLE: begin
                    if (sw_mstatus_we_i && !take_trap && !take_mret) begin
                        mie_q  <= sw_mstatus_wdata_i[3];
                        mpie_q <= sw_mstatus_wdata_i[7];
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state only, so reset clears them immediately
    always_comb begin
        csr_wr_en_o         = 1'b0;
        csr_wr_addr_o       = 12'h0;
        csr_wr_data_o       = 32'h0;
        flush_o             = 1'b0;
        stall_o             = 1'b0;
        pc_redirect_valid_o = 1'b0;
        pc_redirect_o       = '0;
        case (state_q)
            ST_DRAIN: begin
                flush_o = 1'b1;
                stall_o = 1'b1;
            end
            ST_SAVE_EPC: begin
                stall_o       = 1'b1;
                csr_wr_en_o   = 1'b1;
                csr_wr_addr_o = CSR_MEPC;
                csr_wr_data_o = epc_q;
            end
            ST_SAVE_CAUSE: begin
                stall_o       = 1'b1;
                csr_wr_en_o   = 1'b1;
                csr_wr_addr_o = CSR_MCAUSE;
                csr_wr_data_o = cause_q;
            end
            ST_REDIRECT: begin
                pc_redirect_valid_o = 1'b1;
                pc_redirect_o       = trap_tgt[pc_size_p-1:0];
            end
            ST_MRET: begin
                flush_o             = 1'b1;
                pc_redirect_valid_o = 1'b1;
                pc_redirect_o       = mepc_i[pc_size_p-1:0];
            end
            default: ;
        endcase
    end

    assign mstatus_o = {24'h0, mpie_q, 3'b000, mie_q, 3'b000};

endmodule

// File: tb/tb_iot_riscv_trap_ctrl.sv
// Directed bench for the trap controller: exceptions, vectored IRQs, MRET,
// drain hold, ignored software writes and mid-sequence reset.
module tb_iot_riscv_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        exc_valid = 1'b0;
    logic [3:0]  exc_cause = '0;
    logic        mret = 1'b0;
    logic        irq_ext = 1'b0;
    logic        irq_timer = 1'b0;
    logic        pipe_idle = 1'b1;
    logic [31:0] mtvec = '0;
    logic [31:0] mepc = '0;
    logic        sw_we = 1'b0;
    logic [31:0] sw_wdata = '0;

    logic        csr_wr_en;
    logic [11:0] csr_wr_addr;
    logic [31:0] csr_wr_data;
    logic        flush, stall, redir_valid;
    logic [31:0] redir_pc;
    logic [31:0] mstatus;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    iot_riscv_trap_ctrl #(.pc_size_p(32)) dut (
        .main_clk_i          (clk),
        .main_rst_an_i       (rst_n),
        .ex_instr_valid_i    (instr_valid),
        .ex_pc_i             (ex_pc),
        .ex_exc_valid_i      (exc_valid),
        .ex_exc_cause_i      (exc_cause),
        .ex_mret_i           (mret),
        .irq_ext_i           (irq_ext),
        .irq_timer_i         (irq_timer),
        .pipe_idle_i         (pipe_idle),
        .mtvec_i             (mtvec),
        .mepc_i              (mepc),
        .sw_mstatus_we_i     (sw_we),
        .sw_mstatus_wdata_i  (sw_wdata),
        .csr_wr_en_o         (csr_wr_en),
        .csr_wr_addr_o       (csr_wr_addr),
        .csr_wr_data_o       (csr_wr_data),
        .flush_o             (flush),
        .stall_o             (stall),
        .pc_redirect_valid_o (redir_valid),
        .pc_redirect_o       (redir_pc),
        .mstatus_o           (mstatus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packs the strobe outputs: {wr_en, flush, stall, redirect_valid}
    function automatic logic [31:0] ctl();
        return {28'h0, csr_wr_en, flush, stall, redir_valid};
    endfunction

    initial begin
        // Reset state
        #12;
        chk("rst_ctl", ctl(), 32'h0);
        chk("rst_mstatus", mstatus, 32'h0);
        chk("rst_redir_pc", redir_pc, 32'h0);
        rst_n = 1'b1;
        tick();

        // Software write sets MIE (IDLE, no event)
        sw_we = 1'b1; sw_wdata = 32'h0000_0008;
        tick();
        sw_we = 1'b0;
        chk("sw_mie", mstatus, 32'h08);

        // Exception cause 2 at 0x100, direct mtvec 0x200
        exc_valid = 1'b1; exc_cause = 4'd2; ex_pc = 32'h100; mtvec = 32'h200;
        chk("exc_evt_ctl", ctl(), 32'h0);
        tick();
        exc_valid = 1'b0;
        chk("exc_drain_ctl", ctl(), 32'b0110);
        tick();
        chk("exc_epc_ctl", ctl(), 32'b1010);
        chk("exc_epc_addr", {20'h0, csr_wr_addr}, 32'h341);
        chk("exc_epc_data", csr_wr_data, 32'h100);
        tick();
        chk("exc_cause_addr", {20'h0, csr_wr_addr}, 32'h342);
        chk("exc_cause_data", csr_wr_data, 32'h2);
        tick();
        chk("exc_redir_ctl", ctl(), 32'b0001);
        chk("exc_redir_pc", redir_pc, 32'h200);
        tick();
        chk("exc_idle_ctl", ctl(), 32'h0);
        chk("exc_mstatus", mstatus, 32'h80);

        // MRET with MPIE=1, MIE=0
        mret = 1'b1; mepc = 32'h104;
        tick();
        mret = 1'b0;
        chk("mret_ctl", ctl(), 32'b0101);
        chk("mret_pc", redir_pc, 32'h104);
        tick();
        chk("mret_after_ctl", ctl(), 32'h0);
        chk("mret_mstatus", mstatus, 32'h88);

        // Vectored timer IRQ, MIE=1
        irq_timer = 1'b1; instr_valid = 1'b1; ex_pc = 32'h40; mtvec = 32'h301;
        tick();
        irq_timer = 1'b0; instr_valid = 1'b0;
        chk("tmr_drain_ctl", ctl(), 32'b0110);
        tick();
        chk("tmr_epc_data", csr_wr_data, 32'h40);
        tick();
        chk("tmr_cause_data", csr_wr_data, 32'h8000_0007);
        tick();
        chk("tmr_redir_pc", redir_pc, 32'h31C);
        chk("tmr_redir_ctl", ctl(), 32'b0001);
        tick();
        chk("tmr_mstatus", mstatus, 32'h80);

        // Timer IRQ with MIE=0: nothing happens
        irq_timer = 1'b1; instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("tmr_masked_ctl", ctl(), 32'h0);
        end
        irq_timer = 1'b0; instr_valid = 1'b0;

        // Exception and ext IRQ together: exception wins
        sw_we = 1'b1; sw_wdata = 32'h88;
        tick();
        sw_we = 1'b0;
        chk("sim_mstatus_pre", mstatus, 32'h88);
        exc_valid = 1'b1; exc_cause = 4'd3; irq_ext = 1'b1; instr_valid = 1'b1;
        ex_pc = 32'h200; mtvec = 32'h200;
        tick();
        exc_valid = 1'b0; instr_valid = 1'b0;
        tick();
        chk("sim_epc_data", csr_wr_data, 32'h200);
        tick();
        chk("sim_cause_data", csr_wr_data, 32'h3);
        tick();
        chk("sim_redir_pc", redir_pc, 32'h200);
        tick();
        chk("sim_mstatus_post", mstatus, 32'h80);
        // MRET re-enables MIE; ext IRQ still pending but no valid instr yet
        mret = 1'b1; mepc = 32'h204;
        tick();
        mret = 1'b0;
        chk("sim_mret_pc", redir_pc, 32'h204);
        tick();
        chk("sim_mret_mstatus", mstatus, 32'h88);
        chk("sim_mret_idle", ctl(), 32'h0);
        // Valid instruction returns: ext IRQ taken, vectored
        instr_valid = 1'b1; ex_pc = 32'h204; mtvec = 32'h201;
        tick();
        instr_valid = 1'b0; irq_ext = 1'b0;
        chk("ext_drain_ctl", ctl(), 32'b0110);
        tick();
        chk("ext_epc_data", csr_wr_data, 32'h204);
        tick();
        chk("ext_cause_data", csr_wr_data, 32'h8000_000B);
        tick();
        chk("ext_redir_pc", redir_pc, 32'h22C);
        tick();

        // Drain hold with pipe busy; software write during drain is dropped
        pipe_idle = 1'b0;
        exc_valid = 1'b1; exc_cause = 4'd5; ex_pc = 32'h300; mtvec = 32'h400;
        tick();
        exc_valid = 1'b0;
        sw_we = 1'b1; sw_wdata = 32'h08;
        for (int i = 0; i < 5; i++) begin
            chk("hold_ctl", ctl(), 32'b0110);
            tick();
        end
        sw_we = 1'b0;
        chk("hold_mstatus", mstatus, 32'h80);
        pipe_idle = 1'b1;
        chk("hold_last_ctl", ctl(), 32'b0110);
        tick();
        chk("hold_epc_data", csr_wr_data, 32'h300);
        tick();
        chk("hold_cause_ctl", ctl(), 32'b1010);

        // Reset asserted in SAVE_CAUSE
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_ctl", ctl(), 32'h0);
        chk("mrst_mstatus", mstatus, 32'h0);
        tick();
        chk("mrst_no_redir", ctl(), 32'h0);
        rst_n = 1'b1;
        tick();

        // New exception after reset behaves normally
        exc_valid = 1'b1; exc_cause = 4'd1; ex_pc = 32'h500; mtvec = 32'h600;
        tick();
        exc_valid = 1'b0;
        tick();
        chk("post_epc_data", csr_wr_data, 32'h500);
        tick();
        chk("post_cause_data", csr_wr_data, 32'h1);
        tick();
        chk("post_redir_pc", redir_pc, 32'h600);
        tick();
        chk("post_mstatus", mstatus, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
